// File: rtl/nt_pipe_pkg.sv
// Shared constants and helpers for the Nt-node lane array.
package nt_pipe_pkg;

  localparam int DEPTH_MIN = 3;

  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

  function automatic logic nor2(input logic x, input logic y);
    return ~(x | y);
  endfunction

  // Largest value a w-bit counter can hold.
  function automatic logic [31:0] sat_max(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/nt_lane_cell.sv
// One Nt-node lane: in_a capture, NAND/NOR stage, NOR output register.
// With NT_LANE_PARITY_EN the pre-register result is exported for parity.
import nt_pipe_pkg::*;

module nt_lane_cell (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
`ifdef NT_LANE_PARITY_EN
  output logic q_nxt,
`endif
  output logic q
);

  logic r1, m, p, q_d;

  // m and p are the inverted partial terms, so q = ~r1 & b & c one edge later.
  assign q_d = nor2(m, p);

`ifdef NT_LANE_PARITY_EN
  assign q_nxt = q_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1 <= 1'b0;
      m  <= 1'b0;
      p  <= 1'b0;
      q  <= 1'b0;
    end else begin
      r1 <= a;
      m  <= nand2(b, ~r1);
      p  <= nor2(r1, c);
      q  <= q_d;
    end
  end

endmodule

// File: rtl/nt_pipe_lane_array.sv
// WIDTH-lane Nt-node array with delay stages, valid pipe and a sticky
// saturating trigger counter. NT_LANE_PARITY_EN adds out_par and parity gating.
import nt_pipe_pkg::*;

module nt_pipe_lane_array #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 8,
  parameter int THRESH = 16
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_valid,
  input  logic             clr,
`ifdef NT_LANE_PARITY_EN
  output logic             out_par,
`endif
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] trig_cnt,
  output logic             trig_hit
);

  localparam int EXTRA = DEPTH - DEPTH_MIN;
`ifdef NT_LANE_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int DW = WIDTH + PW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  logic [WIDTH-1:0] q3;
  logic [DW-1:0]    w3, w_out;
  logic [DEPTH:2]   vld_pipe;

`ifdef NT_LANE_PARITY_EN
  logic [WIDTH-1:0] q3_nxt;
  logic             par3;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    nt_lane_cell u_lane (
      .clk  (I1470_clk),
      .rst  (I1477_rst),
      .a    (in_a[i]),
      .b    (in_b[i]),
      .c    (in_c[i]),
`ifdef NT_LANE_PARITY_EN
      .q_nxt(q3_nxt[i]),
`endif
      .q    (q3[i])
    );
  end

`ifdef NT_LANE_PARITY_EN
  // Parity is formed from the lanes' next values so it lands on the same edge as q3.
  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) par3 <= 1'b0;
    else           par3 <= ^q3_nxt;
  end
  assign w3 = {par3, q3};
`else
  assign w3 = q3;
`endif

  if (EXTRA == 0) begin : g_nodly
    assign w_out = w3;
  end else begin : g_dly
    logic [EXTRA-1:0][DW-1:0] dly;
    always_ff @(posedge I1470_clk or posedge I1477_rst) begin
      if (I1477_rst) dly <= '0;
      else begin
        dly[0] <= w3;
        for (int j = 1; j < EXTRA; j++) dly[j] <= dly[j-1];
      end
    end
    assign w_out = dly[EXTRA-1];
  end

  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) vld_pipe <= '0;
    else begin
      vld_pipe[2] <= in_valid;
      for (int j = 3; j <= DEPTH; j++) vld_pipe[j] <= vld_pipe[j-1];
    end
  end

  assign out_q     = w_out[WIDTH-1:0];
  assign out_valid = vld_pipe[DEPTH];
`ifdef NT_LANE_PARITY_EN
  assign out_par   = w_out[WIDTH];
`endif

  logic             ev;
  logic [CNT_W-1:0] cnt_nxt;

`ifdef NT_LANE_PARITY_EN
  assign ev = out_valid & (|out_q) & out_par;
`else
  assign ev = out_valid & (|out_q);
`endif

  // clr wins over a coincident event; the count never wraps.
  always_comb begin
    cnt_nxt = trig_cnt;
    if (clr)                              cnt_nxt = '0;
    else if (ev && (trig_cnt != CNT_MAX)) cnt_nxt = trig_cnt + CNT_W'(1);
  end

  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      trig_cnt <= '0;
      trig_hit <= 1'b0;
    end else begin
      trig_cnt <= cnt_nxt;
      trig_hit <= clr ? 1'b0 : (trig_hit | (cnt_nxt >= THR));
    end
  end

endmodule

// File: tb/tb_nt_pipe_lane_array.sv
// Directed bench: two instances (DEPTH=3/CNT_W=8 and DEPTH=5/CNT_W=2, THRESH=3)
// share stimulus; an input-history model is checked every negedge.
module tb_nt_pipe_lane_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0, b = '0, c = '0;
  logic       v = 1'b0, cl = 1'b0;

  logic [3:0] qa, qb;
  logic       va, vb, ha, hb;
  logic [7:0] ca;
  logic [1:0] cb;
`ifdef NT_LANE_PARITY_EN
  logic       pa, pb;
`endif

  always #5 clk = ~clk;

  nt_pipe_lane_array #(.WIDTH(4), .DEPTH(3), .CNT_W(8), .THRESH(3)) dut_a (
    .I1470_clk(clk), .I1477_rst(rst), .in_a(a), .in_b(b), .in_c(c),
    .in_valid(v), .clr(cl),
`ifdef NT_LANE_PARITY_EN
    .out_par(pa),
`endif
    .out_q(qa), .out_valid(va), .trig_cnt(ca), .trig_hit(ha));

  nt_pipe_lane_array #(.WIDTH(4), .DEPTH(5), .CNT_W(2), .THRESH(3)) dut_b (
    .I1470_clk(clk), .I1477_rst(rst), .in_a(a), .in_b(b), .in_c(c),
    .in_valid(v), .clr(cl),
`ifdef NT_LANE_PARITY_EN
    .out_par(pb),
`endif
    .out_q(qb), .out_valid(vb), .trig_cnt(cb), .trig_hit(hb));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: history of sampled inputs per edge; out after edge kk comes from
  // a@(kk-D+1), b/c/valid@(kk-D+2), void if a reset edge lies in that window.
  bit [3:0] ah [0:1023];
  bit [3:0] bh [0:1023];
  bit [3:0] ch [0:1023];
  bit       vh [0:1023];
  int       k = 0;
  int       last_rst = 0;
  int       ma_cnt = 0, mb_cnt = 0;
  bit       ma_hit = 0, mb_hit = 0;

  function automatic bit exp_v(input int d, input int kk);
    int s = kk - d + 2;
    if (s < 2 || kk > 1023 || last_rst >= s) return 1'b0;
    return vh[s];
  endfunction

  function automatic bit [3:0] exp_q(input int d, input int kk);
    return ~ah[kk-d+1] & bh[kk-d+2] & ch[kk-d+2];
  endfunction

  function automatic bit exp_ev(input int d, input int kk);
    bit [3:0] q;
    if (!exp_v(d, kk)) return 1'b0;
    q = exp_q(d, kk);
`ifdef NT_LANE_PARITY_EN
    return (q != 0) && (^q);
`else
    return q != 0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst || cl) begin
      ma_cnt = 0; mb_cnt = 0; ma_hit = 0; mb_hit = 0;
    end else begin
      if (exp_ev(3, k) && ma_cnt < 255) ma_cnt++;
      if (exp_ev(5, k) && mb_cnt < 3)   mb_cnt++;
      if (ma_cnt >= 3) ma_hit = 1;
      if (mb_cnt >= 3) mb_hit = 1;
    end
    k++;
    if (k <= 1023) begin
      ah[k] = rst ? 4'b0 : a;
      bh[k] = b;
      ch[k] = c;
      vh[k] = rst ? 1'b0 : v;
    end
    if (rst) last_rst = k;
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_va", {31'b0, va}, 0); chk("rst_vb", {31'b0, vb}, 0);
      chk("rst_ca", {24'b0, ca}, 0); chk("rst_cb", {30'b0, cb}, 0);
      chk("rst_ha", {31'b0, ha}, 0); chk("rst_hb", {31'b0, hb}, 0);
    end else begin
      chk("a_valid", {31'b0, va}, {31'b0, exp_v(3, k)});
      chk("b_valid", {31'b0, vb}, {31'b0, exp_v(5, k)});
      if (exp_v(3, k)) chk("a_q", {28'b0, qa}, {28'b0, exp_q(3, k)});
      if (exp_v(5, k)) chk("b_q", {28'b0, qb}, {28'b0, exp_q(5, k)});
`ifdef NT_LANE_PARITY_EN
      if (exp_v(3, k)) chk("a_par", {31'b0, pa}, {31'b0, ^exp_q(3, k)});
      if (exp_v(5, k)) chk("b_par", {31'b0, pb}, {31'b0, ^exp_q(5, k)});
`endif
      chk("a_cnt", {24'b0, ca}, ma_cnt); chk("b_cnt", {30'b0, cb}, mb_cnt);
      chk("a_hit", {31'b0, ha}, {31'b0, ma_hit});
      chk("b_hit", {31'b0, hb}, {31'b0, mb_hit});
    end
  end

  // Inputs change 1 time unit after an edge; returns 1 unit after the next edge.
  task automatic ap(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] tc,
                    input logic tv, input logic tcl);
    a = ta; b = tb; c = tc; v = tv; cl = tcl;
    @(posedge clk); #1;
  endtask

  typedef struct { logic [3:0] a, b, c; logic v; } vec_t;
  vec_t mix [6];

  initial begin
    mix[0] = '{4'b1010, 4'b1111, 4'b1110, 1'b1};
    mix[1] = '{4'b0101, 4'b0110, 4'b1111, 1'b1};
    mix[2] = '{4'b0000, 4'b1001, 4'b1011, 1'b0};
    mix[3] = '{4'b1111, 4'b1111, 4'b1111, 1'b1};
    mix[4] = '{4'b0011, 4'b1101, 4'b0111, 1'b1};
    mix[5] = '{4'b1000, 4'b1011, 4'b1110, 1'b1};

    repeat (2) ap(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("reset_q", {28'b0, qa}, 0);
    rst = 1'b0;

    // Lane function and depth
    ap(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);               // E0
    ap(4'b0001, 4'b1111, 4'b0101, 1'b1, 1'b0);               // E1
    ap(4'b0000, 4'b1111, 4'b0101, 1'b1, 1'b0);               // E2
    chk("lit_a_q0101", {28'b0, qa}, 32'h5); chk("lit_a_v", {31'b0, va}, 1);
    chk("lit_b_v_early", {31'b0, vb}, 0);
    ap(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);               // E3
    chk("lit_a_q0100", {28'b0, qa}, 32'h4); chk("lit_a_cnt1", {24'b0, ca}, 1);
    ap(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);               // E4
    chk("lit_b_q0101", {28'b0, qb}, 32'h5); chk("lit_b_v", {31'b0, vb}, 1);
    chk("lit_a_cnt2", {24'b0, ca}, 2);
    ap(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);               // E5
    chk("lit_b_q0100", {28'b0, qb}, 32'h4); chk("lit_b_cnt1", {30'b0, cb}, 1);

    foreach (mix[i]) ap(mix[i].a, mix[i].b, mix[i].c, mix[i].v, 1'b0);
    repeat (6) ap(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Threshold and saturation
    ap(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);                        // S0 clr
    chk("lit_clr_ca", {24'b0, ca}, 0);
    for (int i = 1; i <= 8; i++) begin
      ap(4'h0, 4'hF, 4'hF, 1'b1, 1'b0);
      if (i == 4) begin chk("lit_cnt2", {24'b0, ca}, 2); chk("lit_hit0", {31'b0, ha}, 0); end
      if (i == 5) begin chk("lit_cnt3", {24'b0, ca}, 3); chk("lit_hit1", {31'b0, ha}, 1); end
    end
    chk("lit_sat_cb", {30'b0, cb}, 3); chk("lit_a_cnt6", {24'b0, ca}, 6);
    repeat (6) ap(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("lit_sticky_ha", {31'b0, ha}, 1); chk("lit_idle_va", {31'b0, va}, 0);

    // clr during an event cycle
    repeat (5) ap(4'h0, 4'hF, 4'hF, 1'b1, 1'b0);
    ap(4'h0, 4'hF, 4'hF, 1'b1, 1'b1);
    chk("lit_clr_ca0", {24'b0, ca}, 0); chk("lit_clr_ha0", {31'b0, ha}, 0);
    chk("lit_clr_cb0", {30'b0, cb}, 0); chk("lit_clr_hb0", {31'b0, hb}, 0);
    ap(4'h0, 4'hF, 4'hF, 1'b1, 1'b0);
    chk("lit_after_clr", {24'b0, ca}, 1);

    // Asynchronous reset mid-cycle with all inputs high
    a = 4'hF; b = 4'hF; c = 4'hF; v = 1'b1; cl = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_qa", {28'b0, qa}, 0); chk("async_va", {31'b0, va}, 0);
    chk("async_ca", {24'b0, ca}, 0); chk("async_ha", {31'b0, ha}, 0);
    chk("async_qb", {28'b0, qb}, 0); chk("async_vb", {31'b0, vb}, 0);
    @(posedge clk); #1 rst = 1'b0;
    foreach (mix[i]) ap(mix[i].a, mix[i].b, mix[i].c, mix[i].v, 1'b0);
    repeat (4) ap(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

`ifdef NT_LANE_PARITY_EN
    ap(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);                        // P0 clr
    ap(4'h0, 4'hF, 4'b0011, 1'b1, 1'b0);                     // P1
    ap(4'h0, 4'hF, 4'b0011, 1'b1, 1'b0);                     // P2
    chk("par_q0011", {28'b0, qa}, 32'h3); chk("par_even", {31'b0, pa}, 0);
    ap(4'h0, 4'hF, 4'b0111, 1'b1, 1'b0);                     // P3
    chk("par_nocnt", {24'b0, ca}, 0);
    ap(4'h0, 4'hF, 4'b0111, 1'b1, 1'b0);                     // P4
    chk("par_q0111", {28'b0, qa}, 32'h7); chk("par_odd", {31'b0, pa}, 1);
    ap(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);                        // P5
    chk("par_cnt1", {24'b0, ca}, 1);
    repeat (4) ap(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nt_pipe_lane_array.md
Name: nt_pipe_lane_array

Overview:
- Parametrised successor of the single-lane NOR/NAND + DFFARX1 Nt-node subcircuit used in the trojan-detection benchmarks.
- Replicates the three-register lane function across WIDTH channels and adds configurable pipeline depth and a valid pipeline.
- Adds a saturating rare-event counter with a sticky trigger flag, modelling a counter-based trojan trigger for the detection flow.
- Sits in the Benchmark_testing netlist generator as a reusable leaf.

Parameters:
- WIDTH, 4, number of independent lanes (1..32).
- DEPTH, 3, register stages from the in_a capture to out_q (min 3); stages beyond 3 are pure delay.
- CNT_W, 8, event counter width.
- THRESH, 16, count at which trig_hit asserts (1..2^CNT_W-1).

Ports:
- I1470_clk  in  1  sole clock, rising edge.
- I1477_rst  in  1  asynchronous, active-high reset.
- in_a  in  WIDTH  per-lane early operand, captured one edge before in_b/in_c.
- in_b  in  WIDTH  per-lane NAND operand.
- in_c  in  WIDTH  per-lane NOR operand.
- in_valid  in  1  qualifies in_b/in_c in the same cycle.
- clr  in  1  synchronous clear of counter and trigger.
- out_q  out  WIDTH  lane results.
- out_valid  out  1  qualifies out_q.
- trig_cnt  out  CNT_W  saturating event count.
- trig_hit  out  1  sticky trigger flag.

Behaviour:
- Reset: I1477_rst high clears every flop asynchronously. out_q=0, out_valid=0, trig_cnt=0, trig_hit=0. Deassertion takes effect at the next rising edge. Reset mid-operation discards all in-flight data.
- Lane i, stage 1: r1[i] <= in_a[i].
- Lane i, stage 2:
  - m[i] <= ~(in_b[i] & ~r1[i]).
  - p[i] <= ~(r1[i] | in_c[i]).
  - v2 <= in_valid.
- Lane i, stage 3: q3[i] <= ~(m[i] | p[i]), so q3 = ~a & b & c.
- Timing (DEPTH=3): out_q after edge k = f(in_a@k-2, in_b@k-1, in_c@k-1).
- DEPTH>3: DEPTH-3 additional delay registers on both q and valid. out_valid follows in_valid with DEPTH-1 edges of latency.
- There is no backpressure. A new input is accepted every cycle.
- Event: asserted in any cycle where out_valid=1 and out_q != 0.
- Counter:
  - On an event, trig_cnt increments, saturating at 2^CNT_W-1 with no wrap.
  - trig_hit is registered. It sets on the edge where the next trig_cnt value >= THRESH and stays set until reset or clr.
  - clr=1 zeroes trig_cnt and trig_hit on that edge. clr beats a simultaneous event. clr does not affect the data pipeline.
  - out_valid=0 freezes the counter regardless of out_q.

Optional Feature:
- Macro NT_LANE_PARITY_EN.
- When defined:
  - Adds output out_par (1 bit), registered alongside out_q. It is the XOR of all out_q bits, with the same latency and reset value 0.
  - An event additionally requires out_par=1, i.e. an odd number of active lanes.
- When undefined: out_par is absent and the event rule is as above.

Decomposition:
- Package nt_pipe_pkg: DEPTH_MIN=3, lane function helper (nand/nor form), counter saturation constant function.
- One natural sub-module, nt_lane_cell: a single lane with the three registers and the NOR/NAND logic. It is instantiated WIDTH times via generate. Delay stages, valid pipeline and counter stay in the top.

Test Plan:
- Reset: drive I1477_rst=1 mid-stream with all inputs 1 -> out_q, out_valid, trig_cnt and trig_hit read 0 immediately, before any clock edge.
- Lane function, WIDTH=4, DEPTH=3: in_a=4'b0000 at edge 0, then in_b=4'b1111, in_c=4'b0101, in_valid=1 at edge 1 -> out_q=4'b0101, out_valid=1 after edge 2. Repeating with in_a=4'b0001 gives out_q=4'b0100.
- Depth: DEPTH=5 with the same stimulus -> result appears 2 edges later, and out_valid tracks in_valid with 4-edge latency.
- Threshold: THRESH=3 with continuous events -> trig_cnt=1,2,3 and trig_hit=1 on the same edge as count 3. trig_hit stays 1 when in_valid is later 0.
- Saturation and clr: CNT_W=2 with 5 events -> trig_cnt sticks at 3. Asserting clr during an event cycle -> trig_cnt=0, trig_hit=0 on that edge.
- NT_LANE_PARITY_EN: out_q=4'b0011 -> out_par=0 and no count; out_q=4'b0111 -> out_par=1 and trig_cnt increments.
